// File: rtl/vreg_wb_arbiter.sv
// Round-robin write-back arbiter for the vector register file write port,
// with a 32-entry pending-write scoreboard used for issue-stage hazard checks.
module vreg_wb_arbiter #(
    parameter int VLEN    = 128,
    parameter int NUM_REQ = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      reqValid,
    output logic [NUM_REQ-1:0]      reqReady,
    input  logic [5*NUM_REQ-1:0]    reqAddr,
    input  logic [VLEN*NUM_REQ-1:0] reqData,
    input  logic [4*NUM_REQ-1:0]    reqEnable,
    input  logic [NUM_REQ-1:0]      reqLast,
    input  logic                    issueValid,
    input  logic [4:0]              issueAddr,
    output logic [4:0]              writeAddr,
    output logic [VLEN-1:0]         writeVector,
    output logic [3:0]              writeEnable,
    output logic [31:0]             vregBusy
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] rrPtr_q;
    logic [PTR_W-1:0] rrPtr_d;
    logic             wbValid_q;
    logic             wbLast_q;
    logic [4:0]       writeAddr_q;
    logic [VLEN-1:0]  writeVector_q;
    logic [3:0]       writeEnable_q;
    logic [31:0]      vregBusy_q;
    logic [31:0]      vregBusy_d;

    logic             grantValid;
    logic [PTR_W-1:0] grantIdx;
    logic [4:0]       selAddr;
    logic [VLEN-1:0]  selData;
    logic [3:0]       selEnable;
    logic             selLast;

    // Two passes: first requesters at or above rrPtr, then wrap to the bottom.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grantValid && reqValid[i] && (PTR_W'(i) >= rrPtr_q)) begin
                grantValid = 1'b1;
                grantIdx   = PTR_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grantValid && reqValid[i]) begin
                grantValid = 1'b1;
                grantIdx   = PTR_W'(i);
            end
        end
    end

    always_comb begin
        reqReady  = '0;
        selAddr   = '0;
        selData   = '0;
        selEnable = '0;
        selLast   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grantValid && (grantIdx == PTR_W'(i))) begin
                reqReady[i] = rst_n;
                selAddr     = reqAddr[5*i +: 5];
                selData     = reqData[VLEN*i +: VLEN];
                selEnable   = reqEnable[4*i +: 4];
                selLast     = reqLast[i];
            end
        end
    end

    always_comb begin
        if (grantIdx == PTR_W'(NUM_REQ - 1)) begin
            rrPtr_d = '0;
        end else begin
            rrPtr_d = grantIdx + PTR_W'(1);
        end
    end

    // Clear on commit first so that a same-address issue on this edge wins.
    always_comb begin
        vregBusy_d = vregBusy_q;
        if (wbValid_q && wbLast_q) begin
            vregBusy_d[writeAddr_q] = 1'b0;
        end
        if (issueValid) begin
            vregBusy_d[issueAddr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtr_q       <= '0;
            wbValid_q     <= 1'b0;
            wbLast_q      <= 1'b0;
            writeAddr_q   <= '0;
            writeVector_q <= '0;
            writeEnable_q <= '0;
            vregBusy_q    <= '0;
        end else begin
            vregBusy_q <= vregBusy_d;
            if (grantValid) begin
                rrPtr_q       <= rrPtr_d;
                wbValid_q     <= 1'b1;
                wbLast_q      <= selLast;
                writeAddr_q   <= selAddr;
                writeVector_q <= selData;
                writeEnable_q <= selEnable;
            end else begin
                wbValid_q     <= 1'b0;
                wbLast_q      <= 1'b0;
                writeEnable_q <= '0;
            end
        end
    end

    assign writeAddr   = writeAddr_q;
    assign writeVector = writeVector_q;
    assign writeEnable = writeEnable_q;
    assign vregBusy    = vregBusy_q;

endmodule

// File: tb/tb_vreg_wb_arbiter.sv
// Directed testbench for vreg_wb_arbiter: expected writes are queued when a grant
// is predicted and popped when the output stage presents them.
module tb_vreg_wb_arbiter;

    localparam int VLEN    = 128;
    localparam int NUM_REQ = 3;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_REQ-1:0]      reqValid;
    logic [NUM_REQ-1:0]      reqReady;
    logic [5*NUM_REQ-1:0]    reqAddr;
    logic [VLEN*NUM_REQ-1:0] reqData;
    logic [4*NUM_REQ-1:0]    reqEnable;
    logic [NUM_REQ-1:0]      reqLast;
    logic                    issueValid;
    logic [4:0]              issueAddr;
    logic [4:0]              writeAddr;
    logic [VLEN-1:0]         writeVector;
    logic [3:0]              writeEnable;
    logic [31:0]             vregBusy;

    typedef struct packed {
        logic [4:0]      addr;
        logic [VLEN-1:0] data;
        logic [3:0]      en;
    } wrExp_t;

    wrExp_t expQ[$];
    int compared   = 0;
    int mismatched = 0;

    vreg_wb_arbiter #(.VLEN(VLEN), .NUM_REQ(NUM_REQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reqValid   (reqValid),
        .reqReady   (reqReady),
        .reqAddr    (reqAddr),
        .reqData    (reqData),
        .reqEnable  (reqEnable),
        .reqLast    (reqLast),
        .issueValid (issueValid),
        .issueAddr  (issueAddr),
        .writeAddr  (writeAddr),
        .writeVector(writeVector),
        .writeEnable(writeEnable),
        .vregBusy   (vregBusy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setReq(input int i, input logic v, input logic [4:0] a,
                          input logic [VLEN-1:0] d, input logic [3:0] e, input logic l);
        reqValid[i]              = v;
        reqAddr[5*i +: 5]        = a;
        reqData[VLEN*i +: VLEN]  = d;
        reqEnable[4*i +: 4]      = e;
        reqLast[i]               = l;
    endtask

    task automatic checkOutput(input string tag, input bit expectWrite);
        wrExp_t e;
        if (expectWrite) begin
            check({tag, "_qsize"}, VLEN'(expQ.size()), VLEN'(1));
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                check({tag, "_addr"}, VLEN'(writeAddr), VLEN'(e.addr));
                check({tag, "_en"}, VLEN'(writeEnable), VLEN'(e.en));
                check({tag, "_data"}, writeVector, e.data);
            end
        end else begin
            check({tag, "_idleEn"}, VLEN'(writeEnable), VLEN'(0));
        end
    endtask

    // Inputs are already driven; check the grant, queue the expected write, clock once.
    task automatic applyStimulus(input string tag, input logic [NUM_REQ-1:0] expReady);
        int w = -1;
        #2;
        check({tag, "_ready"}, VLEN'(reqReady), VLEN'(expReady));
        for (int i = 0; i < NUM_REQ; i++) begin
            if (expReady[i]) w = i;
        end
        if (w >= 0) begin
            expQ.push_back('{addr: reqAddr[5*w +: 5], data: reqData[VLEN*w +: VLEN], en: reqEnable[4*w +: 4]});
        end
        @(posedge clk);
        #1;
        checkOutput(tag, w >= 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        reqValid   = '0;
        reqAddr    = '0;
        reqData    = '0;
        reqEnable  = '0;
        reqLast    = '0;
        issueValid = 1'b0;
        issueAddr  = '0;
        setReq(0, 1'b1, 5'd1, {32{4'h1}}, 4'hF, 1'b0);
        setReq(1, 1'b1, 5'd2, {32{4'h2}}, 4'hF, 1'b0);
        setReq(2, 1'b1, 5'd3, {32{4'h3}}, 4'hF, 1'b0);
        #12;
        check("rst_ready", VLEN'(reqReady), VLEN'(0));
        check("rst_wen", VLEN'(writeEnable), VLEN'(0));
        check("rst_waddr", VLEN'(writeAddr), VLEN'(0));
        check("rst_wvec", writeVector, VLEN'(0));
        check("rst_busy", VLEN'(vregBusy), VLEN'(0));
        rst_n = 1'b1;

        applyStimulus("rr0", 3'b001);
        applyStimulus("rr1", 3'b010);
        applyStimulus("rr2", 3'b100);
        applyStimulus("rr3", 3'b001);
        applyStimulus("rr4", 3'b010);
        applyStimulus("rr5", 3'b100);

        applyStimulus("drop0", 3'b001);
        applyStimulus("drop1", 3'b010);
        reqValid[1] = 1'b0;
        applyStimulus("drop2", 3'b100);
        applyStimulus("drop3", 3'b001);
        applyStimulus("drop4", 3'b100);
        applyStimulus("drop5", 3'b001);

        reqValid   = '0;
        issueValid = 1'b1;
        issueAddr  = 5'd5;
        applyStimulus("issue5", 3'b000);
        issueValid = 1'b0;
        check("busy5_set", VLEN'(vregBusy), VLEN'(32'h20));
        setReq(1, 1'b1, 5'd5, {16{8'hA5}}, 4'hF, 1'b1);
        applyStimulus("single", 3'b010);
        check("busy5_hold", VLEN'(vregBusy), VLEN'(32'h20));
        reqValid = '0;
        applyStimulus("singleIdle", 3'b000);
        check("busy5_clr", VLEN'(vregBusy), VLEN'(0));

        setReq(0, 1'b1, 5'd3, {32{4'hC}}, 4'b0101, 1'b0);
        issueValid = 1'b1;
        issueAddr  = 5'd7;
        applyStimulus("partial", 3'b001);
        issueValid = 1'b0;
        check("busy7_set", VLEN'(vregBusy), VLEN'(32'h80));
        setReq(0, 1'b1, 5'd7, {32{4'hD}}, 4'b0000, 1'b1);
        applyStimulus("zeroEn", 3'b001);
        reqValid = '0;
        check("busy7_hold", VLEN'(vregBusy), VLEN'(32'h80));
        applyStimulus("zeroEnIdle", 3'b000);
        check("busy7_clr", VLEN'(vregBusy), VLEN'(0));

        setReq(1, 1'b1, 5'd9, {32{4'h9}}, 4'hF, 1'b1);
        applyStimulus("wb9a", 3'b010);
        reqValid   = '0;
        issueValid = 1'b1;
        issueAddr  = 5'd9;
        applyStimulus("collSet", 3'b000);
        issueValid = 1'b0;
        check("collSet_busy", VLEN'(vregBusy), VLEN'(32'h200));
        setReq(2, 1'b1, 5'd9, {32{4'hE}}, 4'hF, 1'b1);
        applyStimulus("wb9b", 3'b100);
        reqValid   = '0;
        issueValid = 1'b1;
        issueAddr  = 5'd4;
        applyStimulus("collSplit", 3'b000);
        issueValid = 1'b0;
        check("collSplit_busy", VLEN'(vregBusy), VLEN'(32'h10));

        setReq(0, 1'b1, 5'd10, {32{4'h6}}, 4'hF, 1'b0);
        setReq(1, 1'b1, 5'd11, {32{4'h7}}, 4'hF, 1'b0);
        setReq(2, 1'b1, 5'd12, {16{8'h5A}}, 4'b1010, 1'b0);
        applyStimulus("hold0", 3'b001);
        applyStimulus("hold1", 3'b010);
        applyStimulus("hold2", 3'b100);

        issueValid = 1'b1;
        issueAddr  = 5'd20;
        applyStimulus("preRst", 3'b001);
        issueValid = 1'b0;
        check("preRst_busy", VLEN'(vregBusy), VLEN'(32'h0010_0010));
        rst_n = 1'b0;
        #1;
        check("midRst_wen", VLEN'(writeEnable), VLEN'(0));
        check("midRst_busy", VLEN'(vregBusy), VLEN'(0));
        check("midRst_ready", VLEN'(reqReady), VLEN'(0));
        expQ.delete();
        rst_n = 1'b1;
        applyStimulus("postRst", 3'b001);
        reqValid = '0;
        applyStimulus("finalIdle", 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vreg_wb_arbiter.md
Name: vreg_wb_arbiter

Overview:
- Round-robin arbiter and write-back sequencer for the single write port of the vector register file.
- Accepts write-back requests from NUM_REQ execution units (ALU, load unit, MAC, ...), grants one per cycle, and registers the winner onto writeAddr/writeVector/writeEnable.
- Keeps a 32-entry pending-write scoreboard (vregBusy) that the issue stage uses for RAW/WAW hazard checks.

Parameters:
- VLEN, 128, vector register width in bits; must be a multiple of 4; write-enable group width is VLEN/4.
- NUM_REQ, 3, number of write-back requesters; range 2..8.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- reqValid  input  NUM_REQ  per-requester write request valid
- reqReady  output  NUM_REQ  per-requester grant/accept (combinational)
- reqAddr  input  5*NUM_REQ  destination vreg; requester i uses bits [5i+4:5i]
- reqData  input  VLEN*NUM_REQ  write data; requester i uses slice i
- reqEnable  input  4*NUM_REQ  group write enables; bit 3 is the MS group
- reqLast  input  NUM_REQ  final write of the instruction; clears the scoreboard entry
- issueValid  input  1  instruction issued that will write issueAddr
- issueAddr  input  5  destination vreg of the issued instruction
- writeAddr  output  5  to register file
- writeVector  output  VLEN  to register file
- writeEnable  output  4  to register file; 0 when idle
- vregBusy  output  32  bit r = 1 while vreg r has an outstanding write

Behaviour:
- Reset (async, rst_n=0): writeEnable=0, writeAddr=0, writeVector=0, vregBusy=0, rrPtr=0, internal wbValid=0. All of these hold while rst_n=0. Release is synchronous to the next clk edge.
- Arbitration (combinational):
  - Search reqValid starting at index rrPtr, ascending with wrap mod NUM_REQ; the first set bit wins.
  - reqReady is one-hot on the winner, all-zero if no reqValid.
  - reqReady[i] never asserts without reqValid[i].
  - The output port always accepts, so a grant happens every cycle any request is valid.
- Handshake:
  - A transfer occurs when reqValid[i] & reqReady[i].
  - A requester holds addr/data/enable/last stable while valid and not ready.
  - A requester may drop valid without a grant; no state changes.
- Pointer: on a transfer from i, rrPtr <= (i+1) mod NUM_REQ at the same edge. With no transfer, rrPtr is held. No requester waits more than NUM_REQ-1 grants.
- Output stage:
  - Latency is 1 cycle: at the transfer edge, writeAddr/writeVector <= winner's fields and writeEnable <= winner's reqEnable.
  - With no transfer, writeEnable <= 0; writeAddr/writeVector hold.
  - The register file consumes writeEnable on the following edge.
- Zero-enable request (reqEnable=0000): granted and consumes an arbitration slot. writeEnable stays 0, but reqLast still clears the scoreboard.
- Scoreboard:
  - issueValid sets vregBusy[issueAddr] at the clock edge.
  - A committing write (wbValid & wbLast registered in the output stage) clears vregBusy[writeAddr] at the same edge the register file performs the write. vregBusy therefore drops when the data is in the register file.
  - Set and clear to the same address on the same edge: set wins (busy stays 1).
  - Set and clear to different addresses are both applied.
  - issueValid to an already-busy address: no error, bit stays 1. The issue stage is responsible for stalling on busy.
  - Clear of a non-busy address: no effect.
- Back-to-back: one committed write per cycle; consecutive cycles may target the same address. Same-address writes land in grant order.
- Reset mid-operation: in-flight output-stage write is dropped (writeEnable forced 0 immediately) and the scoreboard is cleared. Requesters see reqReady=0 while in reset.

Test Plan:
- Reset: drive all reqValid=1, pulse rst_n=0 mid-stream -> writeEnable=0, vregBusy=0 within the reset cycle. First grant after release goes to requester 0.
- Single request: req1 valid, addr=5, data=0xA5A5..., enable=1111, last=1, vregBusy[5]=1 beforehand -> reqReady=010 same cycle. Next cycle writeAddr=5, writeEnable=1111, writeVector=data. vregBusy[5]=0 after the following edge.
- Round-robin fairness: all 3 valid for 6 cycles, rrPtr=0 -> grant sequence 0,1,2,0,1,2. With req1 dropped after cycle 1, the sequence continues 2,0,2,0.
- Partial enables: req0 enable=0101 to addr 3 -> writeEnable=0101. Zero-enable with last=1 to addr 7 -> writeEnable=0000 and vregBusy[7] cleared.
- Scoreboard collision: issueValid addr=9 on the same edge a last-write to addr 9 commits -> vregBusy[9]=1. A simultaneous issue to 4 with a clear of 9 -> busy[4]=1, busy[9]=0.
- Stable hold: req2 valid with changing nothing while req0/req1 win -> req2 is granted within 2 cycles with its original data written intact.
